// File: rtl/core_sequencer.sv
// core_sequencer
//   Handshake-driven multi-cycle control sequencer for the RV32 core.
//   Each instruction goes through four phases. FETCH_REQ raises a fetch
//   request. FETCH_WAIT waits for the response and latches it. EXEC lets
//   the decoder and ALU settle. WB pulses the PC and register-file strobes
//   once. An ebreak stops the core in HALT. A fetch that never answers
//   stops it in ERR.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   ifu_req_valid       : fetch request for the current pc (output)
//   ifu_req_ready       : fetch port accepts the request
//   ifu_rsp_valid       : fetched word present on ifu_rsp_inst
//   ifu_rsp_inst [31:0] : fetched instruction word
//   inst [31:0]         : latched instruction for the decoder (output)
//   dec_wen, dec_halt   : decoder write enable / ebreak flag for inst
//   rf_we, pc_we        : register-file and PC write strobes (outputs)
//   halted, fetch_err   : terminal status flags (outputs)
//   state [2:0]         : state encoding for debug (output)
//   cycle_cnt           : running cycle count (output)
//   instret_cnt         : retired instruction count (output)
module core_sequencer #(
  parameter int          CNT_W         = 32,
  parameter int          FETCH_TIMEOUT = 16,
  parameter logic [31:0] RESET_INST    = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst,
  input  logic             dec_wen,
  input  logic             dec_halt,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic             fetch_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    WB         = 3'd3,
    HALT       = 3'd4,
    ERR        = 3'd5
  } state_e;

  // The wait counter only has to reach FETCH_TIMEOUT-1.
  localparam int                WAIT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  // State, instruction latch, wait counter and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      inst_q    <= RESET_INST;
      wait_q    <= {WAIT_W{1'b0}};
      cycle_q   <= {CNT_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic and the register updates that go with each transition.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    wait_d    = wait_q;
    instret_d = instret_q;

    case (state_q)
      FETCH_REQ: begin
        if (ifu_req_ready) begin
          state_d = FETCH_WAIT;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_inst;
          state_d = EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      EXEC: begin
        // An ebreak retires here without touching the PC or register file.
        if (dec_halt) begin
          state_d   = HALT;
          instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        state_d   = FETCH_REQ;
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = FETCH_REQ;
    endcase

    // The cycle counter stops together with the core.
    if ((state_q == HALT) || (state_q == ERR)) begin
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // rf_we is the only output that follows an input (dec_wen) combinationally.
  assign ifu_req_valid = (state_q == FETCH_REQ);
  assign pc_we         = (state_q == WB);
  assign rf_we         = (state_q == WB) & dec_wen;
  assign halted        = (state_q == HALT);
  assign fetch_err     = (state_q == ERR);
  assign inst          = inst_q;
  assign state         = state_q;
  assign cycle_cnt     = cycle_q;
  assign instret_cnt   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic          ifu_rsp_valid;
  logic [31:0]   ifu_rsp_inst;
  logic [31:0]   inst;
  logic          dec_wen;
  logic          dec_halt;
  logic          rf_we;
  logic          pc_we;
  logic          halted;
  logic          fetch_err;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instret_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cycle = 0;
  int n_ret = 0;

  core_sequencer #(.CNT_W(CW), .FETCH_TIMEOUT(4), .RESET_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst(inst), .dec_wen(dec_wen), .dec_halt(dec_halt),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .fetch_err(fetch_err),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_inst  = 32'h0;
    dec_wen       = 1'b0;
    dec_halt      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cycle = 0;
    n_ret = 0;
  endtask

  // One zero-wait instruction with stray responses in REQ, EXEC and WB.
  task automatic run_instr(input logic [31:0] ins, input logic wen);
    int strobes;
    strobes = 0;
    dec_wen = wen;
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hBAD0_0001;
    #1; strobes += int'(rf_we) + int'(pc_we);
    tick();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = ins;
    #1; checks++; if (state !== 3'd1) begin errors++; $display("FAIL ri_wait: state got %0d expected 1", state); end
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hBAD0_0002;
    #1; strobes += int'(rf_we) + int'(pc_we);
    checks++; if (inst !== ins) begin errors++; $display("FAIL ri_exec_inst: got %h expected %h", inst, ins); end
    tick();
    ifu_req_ready = 1'b1; ifu_rsp_inst = 32'hBAD0_0003;
    #1; checks++; if ({pc_we, rf_we} !== {1'b1, wen}) begin errors++; $display("FAIL ri_wb_strobes: pc_we/rf_we got %b%b expected 1%b", pc_we, rf_we, wen); end
    tick();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    exp_cycle += 4; n_ret++;
    #1; checks++; if (strobes !== 0) begin errors++; $display("FAIL ri_stray_strobes: got %0d expected 0", strobes); end
    checks++; if ({state, inst} !== {3'd0, ins}) begin errors++; $display("FAIL ri_end: state/inst got %0d/%h expected 0/%h", state, inst, ins); end
    dec_wen = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL rst_inst: got %h expected 00000013", inst); end
    checks++; if ({cycle_cnt, instret_cnt} !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h/%h expected 0/0", cycle_cnt, instret_cnt); end
    checks++; if ({ifu_req_valid, rf_we, pc_we, halted, fetch_err} !== 5'b10000) begin errors++; $display("FAIL rst_outs: got %b expected 10000", {ifu_req_valid, rf_we, pc_we, halted, fetch_err}); end
  endtask

  task automatic test_zero_wait();
    ifu_req_ready = 1'b1;
    #1; checks++; if (ifu_req_valid !== 1'b1) begin errors++; $display("FAIL zw_req: got %b expected 1", ifu_req_valid); end
    tick();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0050_0093;
    #1; checks++; if ({state, ifu_req_valid} !== {3'd1, 1'b0}) begin errors++; $display("FAIL zw_wait: state/req got %0d/%b expected 1/0", state, ifu_req_valid); end
    tick();
    ifu_rsp_valid = 1'b0; dec_wen = 1'b1;
    #1; checks++; if ({state, inst} !== {3'd2, 32'h0050_0093}) begin errors++; $display("FAIL zw_exec: state/inst got %0d/%h expected 2/00500093", state, inst); end
    checks++; if ({pc_we, rf_we} !== 2'b00) begin errors++; $display("FAIL zw_exec_strobes: got %b expected 00", {pc_we, rf_we}); end
    tick();
    checks++; if ({state, pc_we, rf_we} !== {3'd3, 2'b11}) begin errors++; $display("FAIL zw_wb: state/strobes got %0d/%b expected 3/11", state, {pc_we, rf_we}); end
    tick();
    checks++; if ({pc_we, rf_we} !== 2'b00) begin errors++; $display("FAIL zw_after_wb: got %b expected 00", {pc_we, rf_we}); end
    checks++; if ({cycle_cnt, instret_cnt} !== {4'd4, 4'd1}) begin errors++; $display("FAIL zw_cnt: got %0d/%0d expected 4/1", cycle_cnt, instret_cnt); end
    dec_wen = 1'b0;
    exp_cycle = 4; n_ret = 1;
  endtask

  task automatic test_backpressure();
    int reqs, pcs, pc_at;
    reqs = 0; pcs = 0; pc_at = -1;
    for (int i = 0; i < 8; i++) begin
      ifu_req_ready = (i == 3);
      ifu_rsp_valid = (i == 5);
      ifu_rsp_inst  = 32'h00A0_0113;
      #1;
      reqs += int'(ifu_req_valid);
      pcs  += int'(pc_we);
      if (pc_we) pc_at = i;
      tick();
    end
    idle_inputs();
    exp_cycle += 8; n_ret++;
    checks++; if (reqs !== 4) begin errors++; $display("FAIL bp_req_cycles: got %0d expected 4", reqs); end
    checks++; if ({pcs, pc_at} !== {32'sd1, 32'sd7}) begin errors++; $display("FAIL bp_pc_we: count/cycle got %0d/%0d expected 1/7", pcs, pc_at); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL bp_period: state got %0d expected 0", state); end
    checks++; if ({cycle_cnt, instret_cnt} !== {4'(exp_cycle), 4'(n_ret)}) begin errors++; $display("FAIL bp_cnt: got %0d/%0d expected %0d/%0d", cycle_cnt, instret_cnt, 4'(exp_cycle), 4'(n_ret)); end
  endtask

  task automatic test_stray();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hDEAD_BEEF;
    tick();
    ifu_rsp_valid = 1'b0;
    exp_cycle += 1;
    checks++; if ({state, inst} !== {3'd0, 32'h00A0_0113}) begin errors++; $display("FAIL stray_req: state/inst got %0d/%h expected 0/00a00113", state, inst); end
    run_instr(32'h0030_0193, 1'b1);
  endtask

  task automatic test_wrap();
    while (n_ret < 15) run_instr(32'h0010_8093, 1'b0);
    checks++; if (instret_cnt !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", instret_cnt); end
    run_instr(32'h0010_8093, 1'b1);
    checks++; if (instret_cnt !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", instret_cnt); end
    checks++; if (cycle_cnt !== 4'(exp_cycle)) begin errors++; $display("FAIL wrap_cycle: got %0d expected %0d", cycle_cnt, 4'(exp_cycle)); end
  endtask

  task automatic test_timeout();
    logic [CW-1:0] frozen;
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    exp_cycle += 1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++; if ({state, fetch_err} !== {3'd1, 1'b0}) begin errors++; $display("FAIL to_wait%0d: state/err got %0d/%b expected 1/0", i, state, fetch_err); end
      tick();
      exp_cycle += 1;
    end
    checks++; if ({state, fetch_err, ifu_req_valid} !== {3'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL to_err: state/err/req got %0d/%b/%b expected 5/1/0", state, fetch_err, ifu_req_valid); end
    checks++; if (cycle_cnt !== 4'(exp_cycle)) begin errors++; $display("FAIL to_cycle: got %0d expected %0d", cycle_cnt, 4'(exp_cycle)); end
    frozen = cycle_cnt;
    ifu_rsp_valid = 1'b1; ifu_req_ready = 1'b1;
    repeat (3) tick();
    checks++; if ({state, cycle_cnt} !== {3'd5, 4'(exp_cycle)}) begin errors++; $display("FAIL to_frozen: state/cycle got %0d/%0d expected 5/%0d", state, cycle_cnt, frozen); end
    // Response on the last allowed WAIT cycle is still taken.
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (3) tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0040_0213;
    tick();
    ifu_rsp_valid = 1'b0;
    checks++; if ({state, fetch_err, inst} !== {3'd2, 1'b0, 32'h0040_0213}) begin errors++; $display("FAIL to_late_rsp: state/err/inst got %0d/%b/%h expected 2/0/00400213", state, fetch_err, inst); end
    checks++; if (cycle_cnt !== 4'd5) begin errors++; $display("FAIL to_late_cycle: got %0d expected 5", cycle_cnt); end
    tick();
    tick();
  endtask

  task automatic test_ebreak();
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0010_0073;
    tick();
    ifu_rsp_valid = 1'b0; dec_halt = 1'b1; dec_wen = 1'b1;
    #1; checks++; if ({state, pc_we, rf_we} !== {3'd2, 2'b00}) begin errors++; $display("FAIL eb_exec: state/strobes got %0d/%b expected 2/00", state, {pc_we, rf_we}); end
    tick();
    checks++; if ({state, halted, pc_we, rf_we} !== {3'd4, 3'b100}) begin errors++; $display("FAIL eb_halt: state/halted/strobes got %0d/%b/%b expected 4/1/00", state, halted, {pc_we, rf_we}); end
    checks++; if ({cycle_cnt, instret_cnt} !== {4'd3, 4'd1}) begin errors++; $display("FAIL eb_cnt: got %0d/%0d expected 3/1", cycle_cnt, instret_cnt); end
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
    repeat (3) tick();
    checks++; if ({state, cycle_cnt, instret_cnt, pc_we} !== {3'd4, 4'd3, 4'd1, 1'b0}) begin errors++; $display("FAIL eb_frozen: state/cycle/instret/pc_we got %0d/%0d/%0d/%b expected 4/3/1/0", state, cycle_cnt, instret_cnt, pc_we); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0050_0093;
    tick();
    ifu_rsp_valid = 1'b0; dec_wen = 1'b1; rst = 1'b1;
    #1; checks++; if (state !== 3'd2) begin errors++; $display("FAIL rm_in_exec: state got %0d expected 2", state); end
    tick();
    checks++; if ({state, pc_we, rf_we, inst} !== {3'd0, 2'b00, 32'h0000_0013}) begin errors++; $display("FAIL rm_state: state/strobes/inst got %0d/%b/%h expected 0/00/00000013", state, {pc_we, rf_we}, inst); end
    checks++; if ({cycle_cnt, instret_cnt} !== 8'h00) begin errors++; $display("FAIL rm_cnt: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt); end
    ifu_req_ready = 1'b1;
    tick();
    checks++; if ({state, cycle_cnt} !== {3'd0, 4'd0}) begin errors++; $display("FAIL rm_handshake: state/cycle got %0d/%0d expected 0/0", state, cycle_cnt); end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_stray();
    test_wrap();
    test_timeout();
    test_ebreak();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32 core. It replaces the free-running three-phase clock counter with a handshake-driven state machine. It fetches each instruction over a valid/ready request plus response-valid interface and latches it for the decoder. It then issues the register-file write strobe and the PC-update strobe exactly once per instruction, and maintains cycle and retired-instruction counters and halt/error status.

## Interface
Parameters:
- `CNT_W`, 32: width of the cycle and instret counters.
- `FETCH_TIMEOUT`, 16: maximum cycles in FETCH_WAIT before the error state. Must be ≥ 1.
- `RESET_INST`, 32'h0000_0013: value of `inst` after reset (addi x0,x0,0).

Ports:
- `clk`, input, 1: the single clock. All logic is on its posedge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `ifu_req_valid`, output, 1: fetch request for the current `pc`.
- `ifu_req_ready`, input, 1: fetch port accepts the request.
- `ifu_rsp_valid`, input, 1: fetched instruction is present on `ifu_rsp_inst`.
- `ifu_rsp_inst`, input, 32: fetched instruction word.
- `inst`, output, 32: latched instruction, driven to the decoder.
- `dec_wen`, input, 1: the decoder's register-file write enable for `inst`.
- `dec_halt`, input, 1: the decoder flags `inst` as ebreak.
- `rf_we`, output, 1: register-file write strobe.
- `pc_we`, output, 1: PC load strobe (PC takes the mux3 output).
- `halted`, output, 1: core stopped by ebreak.
- `fetch_err`, output, 1: core stopped by fetch timeout.
- `state`, output, 3: state encoding, for debug only.
- `cycle_cnt`, output, CNT_W: count of cycles.
- `instret_cnt`, output, CNT_W: count of retired instructions.

## Operation
States and encodings: FETCH_REQ=0, FETCH_WAIT=1, EXEC=2, WB=3, HALT=4, ERR=5. All outputs are Moore outputs decoded from registers, except `rf_we`.

- **FETCH_REQ:** `ifu_req_valid`=1. Stay here until `ifu_req_ready`=1, then go to FETCH_WAIT. The request is never withdrawn once raised. `ifu_rsp_valid` in this state is ignored.
- **FETCH_WAIT:** `ifu_req_valid`=0. The wait counter is cleared on entry.
  - If `ifu_rsp_valid`=1: latch `inst`←`ifu_rsp_inst` and go to EXEC.
  - Otherwise the wait counter increments. If no response has arrived and the counter equals FETCH_TIMEOUT−1, go to ERR.
- **EXEC:** one cycle in which the decoder and ALU settle on the latched `inst`.
  - If `dec_halt`=1: go to HALT. `instret_cnt` increments on this transition, the PC is not updated, and no register is written.
  - Otherwise go to WB.
- **WB:** `pc_we`=1 and `rf_we`=`dec_wen`, both in the same cycle. `instret_cnt` increments. Then go to FETCH_REQ.
- **HALT:** `halted`=1. Terminal until `rst`.
- **ERR:** `fetch_err`=1. Terminal until `rst`.

Strobe rules:
- `rf_we` and `pc_we` are asserted only in WB, so at most once per instruction.
- `rf_we` is suppressed when `rd`=x0 by the register file, not by this block.

Counters:
- `cycle_cnt` increments every non-reset cycle except in HALT and ERR.
- Both counters wrap modulo 2^CNT_W with no saturation.

Ignored inputs:
- `ifu_rsp_valid` is ignored outside FETCH_WAIT.
- `ifu_req_ready` is ignored outside FETCH_REQ.
- `dec_wen` and `dec_halt` are ignored outside EXEC and WB.

## Timing
Reset:
- `rst` sampled high at a posedge gives: state=FETCH_REQ, `inst`=RESET_INST, both counters 0, wait counter 0.
- Resulting outputs: `ifu_req_valid`=1 (FETCH_REQ), `rf_we`=0, `pc_we`=0, `halted`=0, `fetch_err`=0.
- `rst` has priority over every event in the same cycle. A handshake or response coincident with `rst` is discarded. Reset mid-instruction abandons it with no strobes and no counter increments.

Latency:
- Minimum is 4 cycles per instruction: REQ (accepted), WAIT (response), EXEC, WB.
- Each cycle `ifu_req_ready` is low adds one cycle. Each cycle of response latency beyond one adds one cycle.
- The response may arrive no earlier than the cycle after acceptance.

Timeout:
- The response is still accepted on the FETCH_TIMEOUT-th WAIT cycle.
- Absence of a response on that cycle gives ERR on the next cycle.

Strobe-to-register relationship:
- The PC and register file capture on the posedge that ends WB.
- The new `pc` is visible in the following FETCH_REQ.
- `PCadd4` and the ALU result used in WB are computed from the pre-update `pc`.

## Test plan
- **Reset with zero-wait fetch:** reset 2 cycles; `ifu_req_ready`=1; response 1 cycle after accept carrying 32'h00500093 (addi x1,x0,5), `dec_wen`=1 → `ifu_req_valid` high in REQ; `inst`=32'h00500093 in EXEC; `rf_we`=`pc_we`=1 in WB only; `instret_cnt`=1 and `cycle_cnt`=4 after WB.
- **Backpressure:** `ifu_req_ready` low for 3 cycles, response latency 2 → `ifu_req_valid` held 4 cycles; instruction period 8 cycles; exactly one `pc_we` pulse.
- **Timeout:** FETCH_TIMEOUT=4, no response → ERR after 4 WAIT cycles; `fetch_err`=1; `cycle_cnt` frozen. Repeat with response on the 4th WAIT cycle → EXEC, no error.
- **ebreak:** `dec_halt`=1 in EXEC → HALT; no `pc_we` or `rf_we`; `instret_cnt` increments; `halted`=1; counters frozen.
- **Reset mid-operation:** assert `rst` in EXEC with `dec_wen`=1 → no strobes, `inst`=32'h00000013, counters 0, state FETCH_REQ.
- **Stray and wrap:** `ifu_rsp_valid` pulsed in REQ/EXEC/WB is ignored and `inst` is unchanged; with CNT_W=4, the 16th retirement gives `instret_cnt`=0.
